// File: rtl/fifo_sync_param.sv
`default_nettype none
//==============================================================================
// Module   : fifo_sync_param
// Summary  : Parametrised single-clock FIFO with occupancy count, programmable
//            almost-full/almost-empty flags and sticky overflow/underflow flags.
//            Define FIFO_FWFT_EN for a first-word fall-through read port.
// Revision : 1.0 - initial release
//==============================================================================
module fifo_sync_param #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = 12,
    parameter int AEMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr_err,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_almost_full,
    output logic              fifo_almost_empty,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam int              c_depth     = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] c_afull_th  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] c_aempty_th = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] r_mem [0:c_depth-1];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W:0]   w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_ar;
    logic              w_aw;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Extra wrap bit distinguishes full from empty when the low bits match
    always_comb begin
        w_count   = r_wptr - r_rptr;
        w_empty   = (r_wptr == r_rptr);
        w_full    = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                    (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
        w_ar      = rd & ~w_empty;
        w_aw      = wr & (~w_full | rd);
        w_ovf_set = wr & w_full & ~rd;
        w_udf_set = rd & w_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_aw) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_ar) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_aw) begin
            r_mem[r_wptr[ADDR_W-1:0]] <= data_in;
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is presented combinationally; rd consumes it
    always_comb begin
        data_out   = r_mem[r_rptr[ADDR_W-1:0]];
        data_valid = ~w_empty;
    end
`else
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
        end else begin
            r_data_valid <= w_ar;
            if (w_ar) begin
                r_data_out <= r_mem[r_rptr[ADDR_W-1:0]];
            end
        end
    end

    always_comb begin
        data_out   = r_data_out;
        data_valid = r_data_valid;
    end
`endif

    always_comb begin
        fifo_count        = w_count;
        fifo_full         = w_full;
        fifo_empty        = w_empty;
        fifo_almost_full  = (w_count >= c_afull_th);
        fifo_almost_empty = (w_count <= c_aempty_th);
        fifo_overflow     = r_overflow;
        fifo_underflow    = r_underflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
//==============================================================================
// Module   : tb_fifo_sync_param
// Summary  : Self-checking bench for fifo_sync_param against a queue model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_fifo_sync_param;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr;
    logic          rd;
    logic          clr_err;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [AW:0]   fifo_count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_almost_full;
    logic          fifo_almost_empty;
    logic          fifo_overflow;
    logic          fifo_underflow;

    fifo_sync_param #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .AFULL_TH  (AF),
        .AEMPTY_TH (AE)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .wr                (wr),
        .rd                (rd),
        .clr_err           (clr_err),
        .data_in           (data_in),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .fifo_count        (fifo_count),
        .fifo_full         (fifo_full),
        .fifo_empty        (fifo_empty),
        .fifo_almost_full  (fifo_almost_full),
        .fifo_almost_empty (fifo_almost_empty),
        .fifo_overflow     (fifo_overflow),
        .fifo_underflow    (fifo_underflow)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;

    // Reference model: contents as a queue, flags as plain bits
    logic [DW-1:0] q [$];
    bit            m_ovf;
    bit            m_udf;
    logic [DW-1:0] m_dout;
    bit            m_valid;

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        m_dout  = '0;
        m_valid = 1'b0;
    endtask

    // One clock with the given request; outputs are stable 1ns after the edge
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input bit c);
        bit was_full;
        bit was_empty;
        wr        = w;
        rd        = r;
        data_in   = d;
        clr_err   = c;
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        @(posedge clk);
        if (r && !was_empty) begin
            m_dout  = q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (w && (!was_full || r)) q.push_back(d);
        if (w && was_full && !r) m_ovf = 1'b1;
        else if (c)              m_ovf = 1'b0;
        if (r && was_empty)      m_udf = 1'b1;
        else if (c)              m_udf = 1'b0;
        #1;
        wr      = 1'b0;
        rd      = 1'b0;
        clr_err = 1'b0;
    endtask

    // Performs one read and returns the word the read delivered
    task automatic pop_word(output logic [DW-1:0] got, output logic vld);
`ifdef FIFO_FWFT_EN
        got = data_out;
        vld = data_valid;
        cycle(1'b0, 1'b1, '0, 1'b0);
`else
        cycle(1'b0, 1'b1, '0, 1'b0);
        got = data_out;
        vld = data_valid;
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1; wr = 1'b0; rd = 1'b0; clr_err = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_tests++; if (fifo_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
        n_tests++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", fifo_empty); end
        n_tests++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", fifo_full); end
        n_tests++; if (fifo_almost_empty !== 1'b1 || fifo_almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_almost: got ae=%b af=%b expected ae=1 af=0", fifo_almost_empty, fifo_almost_full); end
        n_tests++; if (fifo_overflow !== 1'b0 || fifo_underflow !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovf=%b udf=%b expected 0 0", fifo_overflow, fifo_underflow); end
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
`ifndef FIFO_FWFT_EN
        n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill_drain();
        logic [DW-1:0] got;
        logic          vld;
        for (int i = 1; i <= DEPTH; i++) begin
            cycle(1'b1, 1'b0, DW'(i), 1'b0);
            n_tests++; if (fifo_count !== 5'(i)) begin n_fail++; $display("FAIL fill_count: got %0d expected %0d", fifo_count, i); end
            n_tests++; if (fifo_full !== (i == DEPTH)) begin n_fail++; $display("FAIL fill_full[%0d]: got %b expected %b", i, fifo_full, i == DEPTH); end
            n_tests++; if (fifo_almost_full !== (i >= AF)) begin n_fail++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, fifo_almost_full, i >= AF); end
            n_tests++; if (fifo_almost_empty !== (i <= AE)) begin n_fail++; $display("FAIL fill_aempty[%0d]: got %b expected %b", i, fifo_almost_empty, i <= AE); end
        end
        for (int i = 1; i <= DEPTH; i++) begin
            pop_word(got, vld);
            n_tests++; if (got !== DW'(i) || vld !== 1'b1) begin n_fail++; $display("FAIL drain_data[%0d]: got %h/%b expected %h/1", i, got, vld, DW'(i)); end
        end
        n_tests++; if (fifo_empty !== 1'b1 || fifo_count !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", fifo_empty, fifo_count); end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL valid_one_cycle: got %b expected 0", data_valid); end
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] got;
        logic          vld;
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        n_tests++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL full_rw_ovf: got %b expected 0", fifo_overflow); end
        n_tests++; if (fifo_count !== 5'd16) begin n_fail++; $display("FAIL full_rw_count: got %0d expected 16", fifo_count); end
        for (int i = 2; i <= DEPTH; i++) begin
            pop_word(got, vld);
            n_tests++; if (got !== DW'(i)) begin n_fail++; $display("FAIL full_rw_data[%0d]: got %h expected %h", i, got, DW'(i)); end
        end
        pop_word(got, vld);
        n_tests++; if (got !== 8'hAA) begin n_fail++; $display("FAIL full_rw_last: got %h expected aa", got); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] got;
        logic          vld;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DW'(8'h40 + i), 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        n_tests++; if (fifo_overflow !== 1'b1 || fifo_count !== 5'd16) begin n_fail++; $display("FAIL ovf_set: got ovf=%b count=%0d expected 1 16", fifo_overflow, fifo_count); end
        cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++; if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", fifo_overflow); end
        cycle(1'b1, 1'b0, 8'hEF, 1'b1);
        n_tests++; if (fifo_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", fifo_overflow); end
        cycle(1'b0, 1'b0, '0, 1'b1);
        n_tests++; if (fifo_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", fifo_overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            pop_word(got, vld);
            n_tests++; if (got !== DW'(8'h40 + i)) begin n_fail++; $display("FAIL ovf_mem[%0d]: got %h expected %h", i, got, DW'(8'h40 + i)); end
        end
    endtask

    task automatic test_underflow();
        logic [DW-1:0] got;
        logic          vld;
        cycle(1'b0, 1'b1, '0, 1'b0);
        n_tests++; if (fifo_underflow !== 1'b1 || fifo_count !== 5'd0 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL udf_set: got udf=%b count=%0d empty=%b expected 1 0 1", fifo_underflow, fifo_count, fifo_empty); end
        cycle(1'b1, 1'b0, 8'h66, 1'b1);
        n_tests++; if (fifo_underflow !== 1'b0 || fifo_count !== 5'd1) begin n_fail++; $display("FAIL udf_clear: got udf=%b count=%0d expected 0 1", fifo_underflow, fifo_count); end
        pop_word(got, vld);
        n_tests++; if (got !== 8'h66 || fifo_empty !== 1'b1) begin n_fail++; $display("FAIL udf_rptr: got %h empty=%b expected 66 1", got, fifo_empty); end
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        n_tests++; if (fifo_count !== 5'd1 || fifo_underflow !== 1'b1) begin n_fail++; $display("FAIL empty_rw: got count=%0d udf=%b expected 1 1", fifo_count, fifo_underflow); end
        pop_word(got, vld);
        n_tests++; if (got !== 8'h55) begin n_fail++; $display("FAIL empty_rw_data: got %h expected 55", got); end
        cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_wrap();
        logic [DW-1:0] got;
        logic          vld;
        for (int i = 0; i < 40; i++) begin
            cycle(1'b1, 1'b0, DW'(8'h80 + i), 1'b0);
            n_tests++; if (fifo_count !== 5'd1) begin n_fail++; $display("FAIL wrap_count[%0d]: got %0d expected 1", i, fifo_count); end
            pop_word(got, vld);
            n_tests++; if (got !== DW'(8'h80 + i) || fifo_overflow || fifo_underflow) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h ovf=%b udf=%b expected %h 0 0", i, got, fifo_overflow, fifo_underflow, DW'(8'h80 + i)); end
        end
    endtask

    task automatic test_mid_reset();
        logic [DW-1:0] got;
        logic          vld;
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(8'h10 + i), 1'b0);
        pop_word(got, vld);
        n_tests++; if (fifo_count !== 5'd7) begin n_fail++; $display("FAIL mid_count: got %0d expected 7", fifo_count); end
        wr = 1'b1; data_in = 8'hC3;
        #1 rst = 1'b1;
        #1;
        model_reset();
        n_tests++; if (fifo_count !== 5'd0 || fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ptr: got count=%0d empty=%b full=%b expected 0 1 0", fifo_count, fifo_empty, fifo_full); end
        n_tests++; if (fifo_almost_empty !== 1'b1 || fifo_almost_full !== 1'b0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_flags: got ae=%b af=%b vld=%b expected 1 0 0", fifo_almost_empty, fifo_almost_full, data_valid); end
`ifndef FIFO_FWFT_EN
        n_tests++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_dout: got %h expected 00", data_out); end
`endif
        wr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 8'h33, 1'b0);
        pop_word(got, vld);
        n_tests++; if (got !== 8'h33 || vld !== 1'b1) begin n_fail++; $display("FAIL mid_rst_reuse: got %h/%b expected 33/1", got, vld); end
    endtask

`ifdef FIFO_FWFT_EN
    task automatic test_fwft();
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        n_tests++; if (data_out !== 8'h77 || data_valid !== 1'b1) begin n_fail++; $display("FAIL fwft_show: got %h/%b expected 77/1", data_out, data_valid); end
        cycle(1'b0, 1'b1, '0, 1'b0);
        n_tests++; if (fifo_empty !== 1'b1 || data_valid !== 1'b0) begin n_fail++; $display("FAIL fwft_pop: got empty=%b vld=%b expected 1 0", fifo_empty, data_valid); end
    endtask
`endif

    task automatic test_random();
        bit w, r, c;
        int n;
        for (int i = 0; i < 3000; i++) begin
            // Alternate producer-heavy and consumer-heavy phases to visit full and empty
            if ((i / 300) % 2 == 0) begin
                w = ($urandom_range(0, 99) < 75);
                r = ($urandom_range(0, 99) < 35);
            end else begin
                w = ($urandom_range(0, 99) < 35);
                r = ($urandom_range(0, 99) < 75);
            end
            c = ($urandom_range(0, 99) < 8);
            cycle(w, r, DW'($urandom), c);
            n = q.size();
            n_tests++; if (fifo_count !== 5'(n)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, fifo_count, n); end
            n_tests++; if (fifo_full !== (n == DEPTH) || fifo_empty !== (n == 0)) begin n_fail++; $display("FAIL rnd_fe[%0d]: got full=%b empty=%b count=%0d", i, fifo_full, fifo_empty, n); end
            n_tests++; if (fifo_almost_full !== (n >= AF) || fifo_almost_empty !== (n <= AE)) begin n_fail++; $display("FAIL rnd_almost[%0d]: got af=%b ae=%b for count %0d", i, fifo_almost_full, fifo_almost_empty, n); end
            n_tests++; if (fifo_overflow !== m_ovf || fifo_underflow !== m_udf) begin n_fail++; $display("FAIL rnd_err[%0d]: got ovf=%b udf=%b expected %b %b", i, fifo_overflow, fifo_underflow, m_ovf, m_udf); end
`ifdef FIFO_FWFT_EN
            n_tests++; if (data_valid !== (n != 0)) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, data_valid, n != 0); end
            if (n != 0) begin
                n_tests++; if (data_out !== q[0]) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h expected %h", i, data_out, q[0]); end
            end
`else
            n_tests++; if (data_valid !== m_valid || data_out !== m_dout) begin n_fail++; $display("FAIL rnd_dout[%0d]: got %h/%b expected %h/%b", i, data_out, data_valid, m_dout, m_valid); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_overflow();
        test_underflow();
        test_wrap();
        test_mid_reset();
`ifdef FIFO_FWFT_EN
        test_fwft();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO; next generation of the 16×8 FIFO memory block. Adds configurable width/depth, an occupancy count, programmable almost-full and almost-empty flags, and simultaneous read/write while full. Overflow and underflow errors are sticky until explicitly cleared. It is the general-purpose single-clock buffer between producer and consumer logic inside one clock domain.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words (≥1)
- AFULL_TH, 12, fifo_almost_full asserts when count ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, fifo_almost_empty asserts when count ≤ AEMPTY_TH (0..DEPTH-1)

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- wr  in  1  write request
- rd  in  1  read request
- clr_err  in  1  synchronous clear of sticky error flags
- data_in  in  DATA_W  write data
- data_out  out  DATA_W  read data
- data_valid  out  1  data_out holds a freshly read word
- fifo_count  out  ADDR_W+1  words stored, 0..DEPTH
- fifo_full, fifo_empty  out  1  count==DEPTH / count==0
- fifo_almost_full, fifo_almost_empty  out  1  threshold flags
- fifo_overflow, fifo_underflow  out  1  sticky error flags

## Operation
- Pointers wptr and rptr are ADDR_W+1 bits wide; the low ADDR_W bits address the memory. The MSB is the wrap bit. Both wrap modulo 2**(ADDR_W+1).
- fifo_count = wptr − rptr, computed modulo 2**(ADDR_W+1).
- fifo_full = (MSBs differ) & (low bits equal); fifo_empty = pointers equal.
- Accepted read: ar = rd & ~fifo_empty.
- Accepted write: aw = wr & (~fifo_full | rd). A write while full is accepted only together with a read.
- On aw: mem[wptr] ← data_in, wptr += 1.
- On ar: rptr += 1.
- When empty, a simultaneous wr & rd performs the write only. The read is refused and counts as underflow.
- fifo_overflow sets when wr & fifo_full & ~rd.
- fifo_underflow sets when rd & fifo_empty.
- Both error flags clear on clr_err. If set and clear occur in the same cycle, set wins.
- Errors never corrupt the pointers or memory.
- Memory contents are not reset.

## Timing
- All flags and fifo_count are combinational from the registered pointers. They reflect an operation in the cycle after its clock edge.
- Standard mode (read): on ar, data_out ← mem[rptr] at the same edge that advances rptr. data_valid = 1 for exactly the following cycle; data_out holds until the next ar.
- Standard mode (write-to-read latency): a word written at edge N is readable (fifo_empty=0) in cycle N+1. It appears on data_out after the read edge.
- Error flags are registered and update on the edge after the offending request.
- Reset values:
  - pointers = 0, fifo_count = 0
  - fifo_empty = 1, fifo_full = 0
  - fifo_almost_empty = 1, fifo_almost_full = 0
  - fifo_overflow = 0, fifo_underflow = 0
  - data_out = 0, data_valid = 0
- Reset asserted mid-operation discards all stored words immediately (asynchronously). The first operation is accepted on the first rising edge after rst deasserts.

## Configuration
- FIFO_FWFT_EN defined: first-word fall-through.
  - data_out = mem[rptr] combinationally, showing the head word whenever fifo_empty = 0.
  - data_valid = ~fifo_empty.
  - rd pops the displayed word.
  - data_out has no reset value, only reset-independent memory contents.
- FIFO_FWFT_EN undefined: standard registered-read behaviour as above.
- The macro affects only data_out and data_valid. Pointers, flags, count and errors are identical in both modes.

## Test plan
- Reset, then write 0x01..0x10 (16 writes, defaults): fifo_full=1 and fifo_count=16 after the 16th edge; fifo_almost_full first asserts after the 12th write. Then read 16: data_out sequence 0x01..0x10, each with data_valid one cycle after rd; fifo_empty=1 at the end.
- Full FIFO, wr=1, rd=1, data_in=0xAA for one cycle: no overflow, count stays 16, 0xAA read last after 15 further reads. Full FIFO with wr=1, rd=0: fifo_overflow=1 next cycle, memory unchanged; clr_err=1 clears it.
- Empty FIFO, rd=1 alone: fifo_underflow=1, rptr unchanged. Empty FIFO with wr=1, rd=1, data_in=0x55: count=1, fifo_underflow=1, the next read returns 0x55.
- Pointer wrap: 40 interleaved write/read pairs with incrementing data: data order preserved, count never exceeds 1, no error flags.
- Assert rst at count=7 mid-burst: all outputs return to their reset values immediately; after deassertion a write of 0x33 followed by a read returns 0x33.
- With FIFO_FWFT_EN: write 0x77 → data_out=0x77 and data_valid=1 in the next cycle with no rd; rd=1 → fifo_empty=1 and data_valid=0 the following cycle.
